// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use stall, branch flush and EX/MEM/WB operand forwarding for the 5-stage pipeline
// Optional HAZARD_STATS_EN adds stall_cnt/flush_cnt event counters.
module hazard_fwd_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_wR,
    input  logic              ex_rf_we,
    input  logic              ex_is_load,
    input  logic [XLEN-1:0]   ex_wd,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   mem_rd,
    output logic              rD1_op,
    output logic              rD2_op,
    output logic [XLEN-1:0]   rD1_forward,
    output logic [XLEN-1:0]   rD2_forward,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex
);

    // Shadow copies of the MEM and WB destinations, fed only from EX.
    logic [REG_AW-1:0] mem_wR, wb_wR;
    logic              mem_we, wb_we, mem_ld;
    logic [XLEN-1:0]   mem_val, wb_val, mem_fwd;

    assign mem_fwd = mem_ld ? mem_rd : mem_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wR  <= '0;
            mem_we  <= 1'b0;
            mem_ld  <= 1'b0;
            mem_val <= '0;
            wb_wR   <= '0;
            wb_we   <= 1'b0;
            wb_val  <= '0;
        end else begin
            mem_wR  <= ex_wR;
            mem_we  <= ex_rf_we;
            mem_ld  <= ex_is_load;
            mem_val <= ex_wd;
            wb_wR   <= mem_wR;
            wb_we   <= mem_we;
            wb_val  <= mem_fwd;
        end
    end

    function automatic logic match(input logic we, input logic [REG_AW-1:0] wr,
                                   input logic [REG_AW-1:0] rs, input logic used);
        return we && (wr == rs) && (rs != '0) && used;
    endfunction

    // Youngest producer wins; a load in EX has no data yet, so fall through to older stages.
    function automatic logic [XLEN:0] pick(input logic h_ex, input logic h_mem, input logic h_wb,
                                           input logic ex_ld, input logic [XLEN-1:0] v_ex,
                                           input logic [XLEN-1:0] v_mem, input logic [XLEN-1:0] v_wb);
        if (h_ex && !ex_ld) return {1'b1, v_ex};
        else if (h_mem)     return {1'b1, v_mem};
        else if (h_wb)      return {1'b1, v_wb};
        else                return '0;
    endfunction

    logic hit1_ex, hit1_mem, hit1_wb;
    logic hit2_ex, hit2_mem, hit2_wb;
    logic [XLEN:0] fwd1, fwd2;
    logic load_use;

    assign hit1_ex  = match(ex_rf_we, ex_wR,  id_rs1, id_rs1_used);
    assign hit1_mem = match(mem_we,   mem_wR, id_rs1, id_rs1_used);
    assign hit1_wb  = match(wb_we,    wb_wR,  id_rs1, id_rs1_used);
    assign hit2_ex  = match(ex_rf_we, ex_wR,  id_rs2, id_rs2_used);
    assign hit2_mem = match(mem_we,   mem_wR, id_rs2, id_rs2_used);
    assign hit2_wb  = match(wb_we,    wb_wR,  id_rs2, id_rs2_used);

    assign fwd1 = pick(hit1_ex, hit1_mem, hit1_wb, ex_is_load, ex_wd, mem_fwd, wb_val);
    assign fwd2 = pick(hit2_ex, hit2_mem, hit2_wb, ex_is_load, ex_wd, mem_fwd, wb_val);

    assign load_use = (hit1_ex || hit2_ex) && ex_is_load;

    assign rD1_op      = !rst && fwd1[XLEN];
    assign rD2_op      = !rst && fwd2[XLEN];
    assign rD1_forward = rst ? '0 : fwd1[XLEN-1:0];
    assign rD2_forward = rst ? '0 : fwd2[XLEN-1:0];

    // A taken redirect squashes the stalled instruction anyway, so it overrides the stall.
    assign stall_pc    = !rst && load_use && !ex_taken;
    assign stall_if_id = stall_pc;
    assign flush_if_id = !rst && ex_taken;
    assign flush_id_ex = !rst && (ex_taken || load_use);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc)    stall_cnt <= stall_cnt + 32'd1;
            if (flush_if_id) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed and randomized checks of hazard_fwd_ctrl against a producer-history model
module tb_hazard_fwd_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_wR;
    logic        id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, ex_taken;
    logic [31:0] ex_wd, mem_rd;
    logic        rD1_op, rD2_op, stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [31:0] rD1_forward, rD2_forward;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] m_stall, m_flush;
`endif

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_wd(ex_wd),
        .ex_taken(ex_taken), .mem_rd(mem_rd),
        .rD1_op(rD1_op), .rD2_op(rD2_op), .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
    );

    // Older producers still in flight, newest first; a load entry resolves its value from mem_rd.
    typedef struct {
        logic [4:0]  wr;
        logic        we;
        logic        ld;
        logic [31:0] val;
    } prod_t;
    prod_t hist[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_fwd(input logic [4:0] rs, input logic used);
        if (rst || !used || rs == 5'd0) return 33'd0;
        if (ex_rf_we && ex_wR == rs && !ex_is_load) return {1'b1, ex_wd};
        foreach (hist[i]) begin
            if (hist[i].we && hist[i].wr == rs) return {1'b1, hist[i].ld ? mem_rd : hist[i].val};
        end
        return 33'd0;
    endfunction

    function automatic logic ref_load_use();
        return !rst && ex_rf_we && ex_is_load &&
               ((id_rs1_used && id_rs1 != 5'd0 && id_rs1 == ex_wR) ||
                (id_rs2_used && id_rs2 != 5'd0 && id_rs2 == ex_wR));
    endfunction

    task automatic compare_all();
        logic [32:0] f1 = ref_fwd(id_rs1, id_rs1_used);
        logic [32:0] f2 = ref_fwd(id_rs2, id_rs2_used);
        logic lu = ref_load_use();
        logic tk = !rst && ex_taken;
        check("rd1_op",      {31'd0, rD1_op},      {31'd0, f1[32]});
        check("rd1_fwd",     rD1_forward,          f1[31:0]);
        check("rd2_op",      {31'd0, rD2_op},      {31'd0, f2[32]});
        check("rd2_fwd",     rD2_forward,          f2[31:0]);
        check("stall_pc",    {31'd0, stall_pc},    {31'd0, lu && !tk});
        check("stall_if_id", {31'd0, stall_if_id}, {31'd0, lu && !tk});
        check("flush_if_id", {31'd0, flush_if_id}, {31'd0, tk});
        check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, tk || lu});
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    task automatic eval();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        prod_t p;
        @(posedge clk);
        if (rst) begin
            hist.delete();
`ifdef HAZARD_STATS_EN
            m_stall = 0;
            m_flush = 0;
`endif
        end else begin
`ifdef HAZARD_STATS_EN
            if (ref_load_use() && !ex_taken) m_stall = m_stall + 1;
            if (ex_taken) m_flush = m_flush + 1;
`endif
            if (hist.size() > 0 && hist[0].ld) begin
                p = hist[0];
                p.val = mem_rd;
                p.ld = 1'b0;
                hist[0] = p;
            end
            p.wr = ex_wR; p.we = ex_rf_we; p.ld = ex_is_load; p.val = ex_wd;
            hist.push_front(p);
            if (hist.size() > 2) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wr, input logic we, input logic ld, input logic [31:0] wd);
        ex_wR = wr; ex_rf_we = we; ex_is_load = ld; ex_wd = wd;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    endtask

    initial begin
        rst = 1'b1; ex_taken = 1'b0; mem_rd = 32'h0;
`ifdef HAZARD_STATS_EN
        m_stall = 0; m_flush = 0;
`endif
        set_ex(5'd5, 1'b1, 1'b1, 32'h55);
        set_id(5'd5, 1'b1, 5'd5, 1'b1);
        @(posedge clk); #1;
        eval();
        check("reset_rd1_op", {31'd0, rD1_op}, 32'd0);
        check("reset_flush", {31'd0, flush_id_ex}, 32'd0);
        advance();
        rst = 1'b0;

        // EX forward
        set_ex(5'd5, 1'b1, 1'b0, 32'h11); set_id(5'd5, 1'b1, 5'd0, 1'b0);
        eval();
        check("ex_fwd_op", {31'd0, rD1_op}, 32'd1);
        check("ex_fwd_val", rD1_forward, 32'h11);
        check("ex_fwd_nostall", {31'd0, stall_pc}, 32'd0);
        advance();

        // priority EX over MEM, then MEM, then WB
        set_ex(5'd3, 1'b1, 1'b0, 32'hB); set_id(5'd0, 1'b0, 5'd0, 1'b0);
        eval(); advance();
        set_ex(5'd3, 1'b1, 1'b0, 32'hA); set_id(5'd0, 1'b0, 5'd3, 1'b1);
        eval();
        check("prio_ex", rD2_forward, 32'hA);
        ex_rf_we = 1'b0;
        #1;
        compare_all();
        check("prio_mem", rD2_forward, 32'hB);
        advance();
        eval();
        check("prio_wb", rD2_forward, 32'hB);
        advance();

        // load-use: one stall cycle, then MEM forwards mem_rd
        set_ex(5'd7, 1'b1, 1'b1, 32'h77); set_id(5'd7, 1'b1, 5'd0, 1'b0);
        eval();
        check("lu_stall_pc", {31'd0, stall_pc}, 32'd1);
        check("lu_stall_ifid", {31'd0, stall_if_id}, 32'd1);
        check("lu_flush_idex", {31'd0, flush_id_ex}, 32'd1);
        advance();
        set_ex(5'd0, 1'b0, 1'b0, 32'h0); mem_rd = 32'hDEAD;
        eval();
        check("lu_after_stall", {31'd0, stall_pc}, 32'd0);
        check("lu_fwd_op", {31'd0, rD1_op}, 32'd1);
        check("lu_fwd_val", rD1_forward, 32'hDEAD);
        advance();

        // taken branch overrides load-use
        rst = 1'b1; eval(); advance(); rst = 1'b0;
        set_ex(5'd9, 1'b1, 1'b1, 32'h99); set_id(5'd9, 1'b1, 5'd0, 1'b0); ex_taken = 1'b1;
        eval();
        check("tk_flush_ifid", {31'd0, flush_if_id}, 32'd1);
        check("tk_flush_idex", {31'd0, flush_id_ex}, 32'd1);
        check("tk_no_stall", {31'd0, stall_pc}, 32'd0);
        advance();
        ex_taken = 1'b0; set_ex(5'd0, 1'b0, 1'b0, 32'h0);
`ifdef HAZARD_STATS_EN
        check("tk_flush_cnt", flush_cnt, 32'd1);
        check("tk_stall_cnt", stall_cnt, 32'd0);
`endif

        // x0 and unused operands never forward or stall
        set_ex(5'd0, 1'b1, 1'b1, 32'h12); set_id(5'd0, 1'b1, 5'd0, 1'b1);
        eval();
        check("x0_op", {31'd0, rD1_op}, 32'd0);
        check("x0_stall", {31'd0, stall_pc}, 32'd0);
        advance();
        set_ex(5'd4, 1'b1, 1'b0, 32'h44); set_id(5'd4, 1'b0, 5'd0, 1'b0);
        eval();
        check("unused_op", {31'd0, rD1_op}, 32'd0);
        advance();

        // reset during a stall clears outputs and shadow producers
        set_ex(5'd6, 1'b1, 1'b0, 32'h66); set_id(5'd0, 1'b0, 5'd0, 1'b0);
        eval(); advance();
        set_ex(5'd6, 1'b1, 1'b1, 32'h67); set_id(5'd6, 1'b1, 5'd0, 1'b0);
        eval();
        check("rs_pre_stall", {31'd0, stall_pc}, 32'd1);
        rst = 1'b1;
        #1;
        compare_all();
        check("rs_stall_cleared", {31'd0, stall_pc}, 32'd0);
        advance();
        rst = 1'b0; set_ex(5'd0, 1'b0, 1'b0, 32'h0);
        eval();
        check("rs_no_old_fwd", {31'd0, rD1_op}, 32'd0);
        advance();

        // randomized traffic over a small register window to provoke frequent hits
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_ex(5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom);
            set_id(5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            ex_taken = ($urandom_range(0, 7) == 0);
            mem_rd = $urandom;
            eval();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Drives the forwarding and flush inputs of the ID/EX pipeline register (rD1_op, rD2_op, rD1_forward, rD2_forward, flush), plus stall and flush for PC and IF/ID.
- Keeps its own shadow copy of the MEM and WB stage destination info, registered from EX-stage signals, so it needs no taps into the later pipeline registers.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- id_rs1  input  REG_AW  rs1 address of the instruction in ID
- id_rs2  input  REG_AW  rs2 address of the instruction in ID
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_wR  input  REG_AW  destination register in EX
- ex_rf_we  input  1  EX instruction writes the register file
- ex_is_load  input  1  EX instruction is a load
- ex_wd  input  XLEN  EX write-back value (ALU result / pc4 / imm, already selected)
- ex_taken  input  1  EX resolved a taken branch or jump
- mem_rd  input  XLEN  DRAM read data for the instruction in MEM
- rD1_op  output  1  select rD1_forward into ID/EX
- rD2_op  output  1  select rD2_forward into ID/EX
- rD1_forward  output  XLEN  forwarded rs1 value
- rD2_forward  output  XLEN  forwarded rs2 value
- stall_pc  output  1  hold PC
- stall_if_id  output  1  hold IF/ID
- flush_if_id  output  1  clear IF/ID
- flush_id_ex  output  1  clear ID/EX (connects to its flush input)

Behaviour:
- Reset: all shadow registers cleared (mem_we=0, wb_we=0, addresses 0, values 0). Every output is combinational from inputs and shadow state; during reset all outputs read 0.
- Shadow pipeline, every clk edge when rst=0, unconditional:
  - mem_wR<=ex_wR; mem_we<=ex_rf_we; mem_ld<=ex_is_load; mem_val<=ex_wd.
  - wb_wR<=mem_wR; wb_we<=mem_we; wb_val<=(mem_ld ? mem_rd : mem_val).
  - A flushed or bubbled EX presents rf_we=0, so bubbles propagate naturally.
- Match, per operand s∈{1,2}: hit_X = X_we && X_wR==id_rs_s && id_rs_s!=0 && id_rs_s_used, for stage X ∈ {ex, mem, wb}.
- Forward priority, youngest first:
  - EX hit and not ex_is_load -> ex_wd.
  - else MEM hit -> (mem_ld ? mem_rd : mem_val).
  - else WB hit -> wb_val.
  - else no forward: rDs_op=0 and rDs_forward=0.
- load_use = (hit_ex for rs1 or rs2) && ex_is_load.
- When load_use && !ex_taken (one cycle):
  - stall_pc=1, stall_if_id=1, flush_id_ex=1.
  - Next cycle the load sits in MEM, the EX bubble has we=0, so load_use deasserts and MEM forwarding supplies mem_rd. Exactly one stall cycle per load-use.
- When ex_taken:
  - flush_if_id=1 and flush_id_ex=1 for that cycle.
  - stall_pc=0 and stall_if_id=0, so the PC takes the redirect target.
  - ex_taken overrides load_use.
- rD*_op may be 1 in a cycle where flush_id_ex=1. This is harmless, because ID/EX ignores flush for rD1/rD2 and control is cleared.
- x0 never forwards and never stalls.
- Reset asserted mid-stall: the stall ends immediately and the shadow state clears. Same-cycle flush and stall: flush wins as stated above.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each ex_taken cycle.
  - Both clear on rst and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- EX: wR=5, we=1, wd=0x11. ID: rs1=5, used. -> rD1_op=1, rD1_forward=0x11, no stall.
- Priority: EX wR=3 wd=0xA, with wR=3 val=0xB one cycle older (now in MEM), ID rs2=3 -> rD2_forward=0xA. Drop the EX write: next compare gives 0xB from MEM, then WB value one cycle later.
- Load-use: EX is_load, wR=7; ID rs1=7 -> one cycle with stall_pc=stall_if_id=flush_id_ex=1. Next cycle with mem_rd=0xDEAD -> stall=0, rD1_op=1, rD1_forward=0xDEAD.
- ex_taken=1 together with load_use=1 -> flush_if_id=flush_id_ex=1, stall_pc=0. With HAZARD_STATS_EN, flush_cnt=1 and stall_cnt=0.
- ID rs1=0 used, EX wR=0, we=1 -> rD1_op=0, no stall. Also rs1_used=0 with a matching address -> rD1_op=0.
- Assert rst during a stall cycle, then release -> all outputs 0; a prior MEM/WB producer no longer forwards (wb_we=0).
